grf_multiport: RTL and testbench
================================

// Module: grf_multiport
// PURPOSE
//  Parametrised general register file for the pipelined CPU. Next generation of the 2R/1W GRF.
//  Provides NUM_RD combinational read ports and two write ports (W0, W1) with same-cycle write-through bypass.
//  Adds a per-register busy scoreboard: set at issue, cleared at writeback.
//  The hazard unit uses the busy flags to generate stalls. Sits between decode (read/issue) and writeback.
// PARAMETERS
//  DATA_W  32  register width in bits
//  ADDR_W  5   register address width; depth = 2**ADDR_W
//  NUM_RD  2   number of read ports, 1..4
// PORTS
//  Clk        in   1               rising-edge clock, single clock domain
//  Reset      in   1               synchronous, active-high reset
//  RAddr      in   NUM_RD*ADDR_W   read addresses; port k = bits [k*ADDR_W +: ADDR_W]
//  RData      out  NUM_RD*DATA_W   read data, combinational; port k = [k*DATA_W +: DATA_W]
//  RBusy      out  NUM_RD          1 = register at RAddr[k] has a pending producer
//  WE0        in   1               write enable, port 0 (low priority)
//  WAddr0     in   ADDR_W          write address, port 0
//  WData0     in   DATA_W          write data, port 0
//  WE1        in   1               write enable, port 1 (high priority)
//  WAddr1     in   ADDR_W          write address, port 1
//  WData1     in   DATA_W          write data, port 1
//  IssueEn    in   1               mark IssueAddr busy at this edge
//  IssueAddr  in   ADDR_W          destination register of the issuing instruction
//  AnyBusy    out  1               OR of all registered busy bits
// BEHAVIOUR
//  Reset (sync, active-high)
//   - At the edge with Reset=1, all registers and all busy bits clear to 0. Writes and issue that cycle are ignored.
//   - While Reset=1, bypass and busy-clear forwarding are suppressed: RData = stored value, RBusy = stored busy bit.
//   - After the reset edge: every RData = 0, RBusy = 0, AnyBusy = 0.
//   - Reset asserted mid-operation discards all pending busy state. No partial writes.
//  Register 0
//   - Reads as 0. Writes to it are ignored. Issue to it never sets busy. It is never bypassed.
//  Writes
//   - A write takes effect at the rising edge. Stored value is visible via storage from the next cycle.
//   - WE0 and WE1 to the same nonzero address: WData1 is stored; WData0 is dropped.
//  Bypass
//   - RData[k] = WData1 if WE1 & WAddr1==RAddr[k] & RAddr[k]!=0.
//   - Else RData[k] = WData0 if WE0 & WAddr0==RAddr[k] & RAddr[k]!=0.
//   - Else RData[k] = stored[RAddr[k]]. Zero-cycle latency, purely combinational.
//  Scoreboard
//   - busy[a] next state, evaluated in this order:
//       1. set if IssueEn & IssueAddr==a & a!=0;
//       2. else cleared if (WE0 & WAddr0==a) | (WE1 & WAddr1==a);
//       3. else hold.
//   - Issue and writeback to the same register in the same cycle: busy stays 1 (new producer wins).
//   - RBusy[k] = busy[RAddr[k]] & ~(a write to RAddr[k] this cycle). Issue does not affect RBusy until the next cycle.
//   - A write to a non-busy register is legal: data is stored, busy stays 0.
//  Widths
//   - No arithmetic. All address compares are full ADDR_W bits.
// STRUCTURE
//  grf_pkg: GRF_DATA_W=32, GRF_ADDR_W=5, GRF_ZERO_ADDR='0, plus the port-slice index helper.
//  Sub-module grf_read_port: one address in -> bypassed data and bypass-aware busy out.
//   Instanced NUM_RD times via generate. Storage and busy vector live in the top.
// TESTING
//  1. Reset=1 for 1 cycle after random writes -> all RData=0, RBusy=0, AnyBusy=0.
//  2. WE0=1, WAddr0=5, WData0=32'hDEADBEEF; RAddr[0]=5 same cycle -> RData[0]=DEADBEEF.
//     Next cycle with WE0=0 -> still DEADBEEF.
//  3. WE0 & WE1 both to reg 7 (data 11, 22); RAddr[1]=7 -> RData[1]=22 this cycle and 22 after the edge.
//  4. WE1=1, WAddr1=0, WData1=FFFF_FFFF; RAddr[0]=0 -> RData[0]=0 this cycle and after. IssueAddr=0 -> AnyBusy stays 0.
//  5. Issue reg 9 -> next cycle RBusy=1, AnyBusy=1.
//     Then issue 9 + WE0 to 9 in the same cycle -> still busy. Next: WE1 to 9 -> RBusy=0 that cycle, busy=0 after.
//  6. Issue regs 3 and 4, then Reset mid-stream -> busy all 0.
//     A WE0 to reg 3 during the Reset cycle is not stored -> RData=0.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared constants and helpers for the general register file.
//   GRF_DATA_W    : default register width
//   GRF_ADDR_W    : default register address width (depth = 2**GRF_ADDR_W)
//   GRF_ZERO_ADDR : hard-wired zero register address
//   grf_slice_lo  : low bit index of port k inside a flattened port bus
package grf_pkg;

  localparam int unsigned GRF_DATA_W = 32;
  localparam int unsigned GRF_ADDR_W = 5;
  localparam logic [GRF_ADDR_W-1:0] GRF_ZERO_ADDR = '0;

  function automatic int unsigned grf_slice_lo(input int unsigned port,
                                               input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/grf_if.sv
// Decode/writeback side bus of the register file.
//   RAddr/RData/RBusy : NUM_RD flattened read ports (port k at slice k)
//   WE0/WAddr0/WData0 : write port 0 (low priority)
//   WE1/WAddr1/WData1 : write port 1 (high priority)
//   IssueEn/IssueAddr : mark destination register busy
//   AnyBusy           : OR of all registered busy bits
// master = pipeline side, slave = register file.
interface grf_if
  import grf_pkg::*;
#(
  parameter int unsigned DATA_W = GRF_DATA_W,
  parameter int unsigned ADDR_W = GRF_ADDR_W,
  parameter int unsigned NUM_RD = 2
) ();

  logic [NUM_RD*ADDR_W-1:0] RAddr;
  logic [NUM_RD*DATA_W-1:0] RData;
  logic [NUM_RD-1:0]        RBusy;
  logic                     WE0;
  logic [ADDR_W-1:0]        WAddr0;
  logic [DATA_W-1:0]        WData0;
  logic                     WE1;
  logic [ADDR_W-1:0]        WAddr1;
  logic [DATA_W-1:0]        WData1;
  logic                     IssueEn;
  logic [ADDR_W-1:0]        IssueAddr;
  logic                     AnyBusy;

  modport master (
    output RAddr, WE0, WAddr0, WData0, WE1, WAddr1, WData1, IssueEn, IssueAddr,
    input  RData, RBusy, AnyBusy
  );

  modport slave (
    input  RAddr, WE0, WAddr0, WData0, WE1, WAddr1, WData1, IssueEn, IssueAddr,
    output RData, RBusy, AnyBusy
  );

endinterface

// File: rtl/grf_read_port.sv
// One combinational read port with write-through bypass.
//   raddr                : read address
//   we*/waddr*/wdata*    : both write ports of the current cycle
//   fwd_en               : 0 disables bypass and busy masking (during reset)
//   stored_data/busy     : storage contents at raddr
//   rdata/rbusy          : bypassed data, busy masked by a same-cycle write
module grf_read_port
  import grf_pkg::*;
#(
  parameter int unsigned DATA_W = GRF_DATA_W,
  parameter int unsigned ADDR_W = GRF_ADDR_W
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              fwd_en,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              stored_busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rbusy
);

  logic nonzero;
  logic hit0;
  logic hit1;

  always_comb begin
    nonzero = (raddr != ADDR_W'(GRF_ZERO_ADDR));
    hit0    = fwd_en & we0 & (waddr0 == raddr) & nonzero;
    hit1    = fwd_en & we1 & (waddr1 == raddr) & nonzero;
    rdata   = stored_data;
    if (hit1) begin
      rdata = wdata1;
    end else if (hit0) begin
      rdata = wdata0;
    end
    // register 0 is never busy, so excluding it from the hit terms is harmless
    rbusy = stored_busy & ~(hit0 | hit1);
  end

endmodule

// File: rtl/grf_multiport.sv
// Multi-port general register file with busy scoreboard.
//   Clk   : rising-edge clock
//   Reset : synchronous active-high reset (clears storage and busy bits)
//   bus   : grf_if slave (NUM_RD read ports, two write ports, issue, AnyBusy)
// Register 0 is hard-wired to zero and never busy.
module grf_multiport
  import grf_pkg::*;
#(
  parameter int unsigned DATA_W = GRF_DATA_W,
  parameter int unsigned ADDR_W = GRF_ADDR_W,
  parameter int unsigned NUM_RD = 2
) (
  input logic  Clk,
  input logic  Reset,
  grf_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(GRF_ZERO_ADDR);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             busy_q, busy_d;

  // W1 is applied after W0 so it wins on an address collision
  always_comb begin
    mem_d = mem_q;
    if (bus.WE0 && bus.WAddr0 != ZERO) mem_d[bus.WAddr0] = bus.WData0;
    if (bus.WE1 && bus.WAddr1 != ZERO) mem_d[bus.WAddr1] = bus.WData1;
  end

  // issue has priority over writeback clear: the new producer owns the register
  always_comb begin
    busy_d    = busy_q;
    busy_d[0] = 1'b0;
    for (int unsigned a = 1; a < DEPTH; a++) begin
      if (bus.IssueEn && bus.IssueAddr == ADDR_W'(a)) begin
        busy_d[a] = 1'b1;
      end else if ((bus.WE0 && bus.WAddr0 == ADDR_W'(a)) ||
                   (bus.WE1 && bus.WAddr1 == ADDR_W'(a))) begin
        busy_d[a] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign bus.AnyBusy = |busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    assign raddr = bus.RAddr[grf_slice_lo(k, ADDR_W) +: ADDR_W];

    grf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .raddr       (raddr),
      .we0         (bus.WE0),
      .waddr0      (bus.WAddr0),
      .wdata0      (bus.WData0),
      .we1         (bus.WE1),
      .waddr1      (bus.WAddr1),
      .wdata1      (bus.WData1),
      .fwd_en      (~Reset),
      .stored_data (mem_q[raddr]),
      .stored_busy (busy_q[raddr]),
      .rdata       (bus.RData[grf_slice_lo(k, DATA_W) +: DATA_W]),
      .rbusy       (bus.RBusy[k])
    );
  end

endmodule

// File: tb/tb_grf_multiport.sv
module tb_grf_multiport;

  typedef struct {
    logic        rst;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_rb;
    logic        e_any;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  vec_t vecs[$];

  grf_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

  grf_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rst_i, input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
    input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
    input logic ie, input logic [4:0] ia, input logic [4:0] ra0, input logic [4:0] ra1,
    input logic [31:0] e_rd0, input logic [31:0] e_rd1, input logic [1:0] e_rb, input logic e_any);
    vec_t v;
    v.rst = rst_i; v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
    v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1; v.ie = ie; v.ia = ia;
    v.ra0 = ra0; v.ra1 = ra1;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_rb = e_rb; v.e_any = e_any;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst           = v.rst;
    bus.WE0       = v.we0;
    bus.WAddr0    = v.wa0;
    bus.WData0    = v.wd0;
    bus.WE1       = v.we1;
    bus.WAddr1    = v.wa1;
    bus.WData1    = v.wd1;
    bus.IssueEn   = v.ie;
    bus.IssueAddr = v.ia;
    bus.RAddr     = {v.ra1, v.ra0};
  endtask

  // drive just after an edge, check combinational outputs before the next edge
  task automatic apply(input vec_t v, input int idx);
    drive(v);
    #3;
    chk("rdata0", idx, bus.RData[31:0], v.e_rd0);
    chk("rdata1", idx, bus.RData[63:32], v.e_rd1);
    chk("rbusy", idx, {30'd0, bus.RBusy}, {30'd0, v.e_rb});
    chk("anybusy", idx, {31'd0, bus.AnyBusy}, {31'd0, v.e_any});
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // after preload: reg i = 32'h1000_0000 + i, regs 1..31 busy
    // test 1: reset with writes/issue pending -> suppressed forwarding, then all clear
    vecs.push_back(mk(1, 1, 3, 32'h0000_00AA, 1, 5, 32'h0000_00BB, 1, 6, 3, 5, 32'h1000_0003, 32'h1000_0005, 2'b11, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 5, 0, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 1, 0, 0, 2'b00, 0));
    // test 2: W0 bypass then stored
    vecs.push_back(mk(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 5, 0, 32'hDEAD_BEEF, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 0));
    // test 3: W0/W1 collision, W1 wins
    vecs.push_back(mk(0, 1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 5, 7, 32'hDEAD_BEEF, 32'h22, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 32'h22, 32'h22, 2'b00, 0));
    // test 4: register 0 ignores writes, bypass and issue
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 7, 0, 32'h22, 2'b00, 0));
    vecs.push_back(mk(0, 1, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    // test 5: scoreboard on reg 9
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 7, 0, 32'h22, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 0, 0, 2'b11, 1));
    vecs.push_back(mk(0, 1, 9, 32'h99, 0, 0, 0, 1, 9, 9, 9, 32'h99, 32'h99, 2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 32'h99, 0, 2'b01, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 9, 32'h77, 0, 0, 9, 7, 32'h77, 32'h22, 2'b00, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 32'h77, 32'h77, 2'b00, 0));
    // test 6: issue 3 and 4, reset mid-stream with a W0 to reg 3
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 4, 0, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 3, 4, 0, 0, 2'b01, 1));
    vecs.push_back(mk(1, 1, 3, 32'h55, 0, 0, 0, 0, 0, 3, 4, 0, 0, 2'b11, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 0, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 5, 0, 0, 2'b00, 0));

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    @(posedge clk);
    #1;

    // preload: every register written and issued in the same cycle (stays busy)
    for (int i = 1; i < 32; i++) begin
      drive(mk(0, 1, 5'(i), 32'h1000_0000 + 32'(i), 0, 0, 0, 1, 5'(i), 0, 0, 0, 0, 2'b00, 0));
      @(posedge clk);
      #1;
    end

    foreach (vecs[i]) apply(vecs[i], i);

    // parallel writes to distinct registers, one non-busy, one busy
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 11, 10, 11, 0, 0, 2'b00, 0), 100);
    apply(mk(0, 1, 10, 32'hA0A0_A0A0, 1, 11, 32'hB1B1_B1B1, 0, 0, 10, 11,
             32'hA0A0_A0A0, 32'hB1B1_B1B1, 2'b00, 1), 101);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 11, 10, 32'hB1B1_B1B1, 32'hA0A0_A0A0, 2'b00, 0), 102);
    // W0-only bypass while W1 targets a different register
    apply(mk(0, 1, 12, 32'h0C0C_0C0C, 1, 13, 32'h0D0D_0D0D, 0, 0, 12, 10,
             32'h0C0C_0C0C, 32'hA0A0_A0A0, 2'b00, 0), 103);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 13, 12, 32'h0D0D_0D0D, 32'h0C0C_0C0C, 2'b00, 0), 104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
